seg_scan_decoder: RTL and testbench

//  Receive side of the 7-segment display interface: snoops multiplexed active-low anode/cathode

---
 rtl/seg_codes_pkg.sv | 49 ++++
 rtl/seg_pattern_decode.sv | 42 ++++
 rtl/seg_scan_decoder.sv | 170 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_codes_pkg.sv
// Shared constants for the 7-segment scan decoder: display codes, segment patterns, FSM states.
package seg_codes_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned SEG_W  = 7;

  // Display codes
  localparam logic [CODE_W-1:0] CODE_0     = 8'h00;
  localparam logic [CODE_W-1:0] CODE_1     = 8'h01;
  localparam logic [CODE_W-1:0] CODE_2     = 8'h02;
  localparam logic [CODE_W-1:0] CODE_3     = 8'h03;
  localparam logic [CODE_W-1:0] CODE_4     = 8'h04;
  localparam logic [CODE_W-1:0] CODE_5     = 8'h05;
  localparam logic [CODE_W-1:0] CODE_6     = 8'h06;
  localparam logic [CODE_W-1:0] CODE_7     = 8'h07;
  localparam logic [CODE_W-1:0] CODE_8     = 8'h08;
  localparam logic [CODE_W-1:0] CODE_9     = 8'h09;
  localparam logic [CODE_W-1:0] CODE_C     = 8'h0C;
  localparam logic [CODE_W-1:0] CODE_R     = 8'h0B;
  localparam logic [CODE_W-1:0] CODE_E     = 8'h0E;
  localparam logic [CODE_W-1:0] CODE_L     = 8'h11;
  localparam logic [CODE_W-1:0] CODE_MINUS = 8'hFE;
  localparam logic [CODE_W-1:0] CODE_EMPTY = 8'hFF;

  // Active-high segment patterns {A,B,C,D,E,F,G}
  localparam logic [SEG_W-1:0] PAT_0     = 7'h7E;
  localparam logic [SEG_W-1:0] PAT_1     = 7'h30;
  localparam logic [SEG_W-1:0] PAT_2     = 7'h6D;
  localparam logic [SEG_W-1:0] PAT_3     = 7'h79;
  localparam logic [SEG_W-1:0] PAT_4     = 7'h33;
  localparam logic [SEG_W-1:0] PAT_5     = 7'h5B;
  localparam logic [SEG_W-1:0] PAT_6     = 7'h5F;
  localparam logic [SEG_W-1:0] PAT_7     = 7'h70;
  localparam logic [SEG_W-1:0] PAT_8     = 7'h7F;
  localparam logic [SEG_W-1:0] PAT_9     = 7'h7B;
  localparam logic [SEG_W-1:0] PAT_C     = 7'h4E;
  localparam logic [SEG_W-1:0] PAT_R     = 7'h46;
  localparam logic [SEG_W-1:0] PAT_E     = 7'h4F;
  localparam logic [SEG_W-1:0] PAT_L     = 7'h0E;
  localparam logic [SEG_W-1:0] PAT_MINUS = 7'h01;
  localparam logic [SEG_W-1:0] PAT_EMPTY = 7'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational segment pattern -> display code lookup.
// Letter codes C/R/E/L are recognised only when SEG_ALPHA_EN is defined.
module seg_pattern_decode
  import seg_codes_pkg::*;
(
  input  logic [SEG_W-1:0]  pattern,
  output logic              known_c,
  output logic [CODE_W-1:0] code_c
);

`ifdef SEG_ALPHA_EN
  localparam bit ALPHA_EN = 1'b1;
`else
  localparam bit ALPHA_EN = 1'b0;
`endif

  // Pattern lookup; 5B is always the digit 5 since S looks identical
  always_comb begin
    known_c = 1'b1;
    code_c  = CODE_EMPTY;
    case (pattern)
      PAT_0:     code_c = CODE_0;
      PAT_1:     code_c = CODE_1;
      PAT_2:     code_c = CODE_2;
      PAT_3:     code_c = CODE_3;
      PAT_4:     code_c = CODE_4;
      PAT_5:     code_c = CODE_5;
      PAT_6:     code_c = CODE_6;
      PAT_7:     code_c = CODE_7;
      PAT_8:     code_c = CODE_8;
      PAT_9:     code_c = CODE_9;
      PAT_MINUS: code_c = CODE_MINUS;
      PAT_EMPTY: code_c = CODE_EMPTY;
      PAT_C: begin known_c = ALPHA_EN; code_c = ALPHA_EN ? CODE_C : CODE_EMPTY; end
      PAT_R: begin known_c = ALPHA_EN; code_c = ALPHA_EN ? CODE_R : CODE_EMPTY; end
      PAT_E: begin known_c = ALPHA_EN; code_c = ALPHA_EN ? CODE_E : CODE_EMPTY; end
      PAT_L: begin known_c = ALPHA_EN; code_c = ALPHA_EN ? CODE_L : CODE_EMPTY; end
      default:   known_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops multiplexed active-low anode/cathode scan lines and rebuilds per-digit display codes.
// Optional letter decoding via the SEG_ALPHA_EN macro (handled in seg_pattern_decode).
module seg_scan_decoder
  import seg_codes_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_DIGITS-1:0]        an_n,
  input  logic [SEG_W-1:0]             seg_n,
  output logic [CODE_W*NUM_DIGITS-1:0] digit_code,
  output logic [NUM_DIGITS-1:0]        digit_valid,
  output logic                         frame_done,
  output logic                         decode_err,
  output logic                         stale
);

  localparam int unsigned KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_DIGITS-1:0] an_s1, an_s2;
  logic [SEG_W-1:0]      seg_s1, seg_s2;
  logic [NUM_DIGITS-1:0] lows;
  logic                  single_c;
  logic [KW-1:0]         cur_k;
  logic [SEG_W-1:0]      seg_p;
  logic                  same_c;

  scan_state_e           state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [KW-1:0]         lat_k, lat_k_nxt;
  logic [SEG_W-1:0]      lat_p, lat_p_nxt;
  logic                  capture_c;

  logic                  dec_known;
  logic [CODE_W-1:0]     dec_code;
  logic [NUM_DIGITS-1:0] seen, seen_upd_c;
  logic [IW-1:0]         idle_cnt;

  // Two-flop synchroniser; reset to the inactive (all-ones) level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1  <= '1;
      an_s2  <= '1;
      seg_s1 <= '1;
      seg_s2 <= '1;
    end else begin
      an_s1  <= an_n;
      an_s2  <= an_s1;
      seg_s1 <= seg_n;
      seg_s2 <= seg_s1;
    end
  end

  // Active digit detection: exactly one anode low gives its index
  always_comb begin
    lows     = ~an_s2;
    seg_p    = ~seg_s2;
    single_c = (lows != '0) && ((lows & (lows - NUM_DIGITS'(1))) == '0);
    cur_k    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lows[i]) cur_k = KW'(i);
    end
    same_c = single_c && (cur_k == lat_k) && (seg_p == lat_p);
  end

  // Capture FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      lat_k <= '0;
      lat_p <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lat_k <= lat_k_nxt;
      lat_p <= lat_p_nxt;
    end
  end

  // Capture FSM next state; a full dwell always captures, even if the sample changes that cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lat_k_nxt = lat_k;
    lat_p_nxt = lat_p;
    capture_c = 1'b0;
    case (state)
      IDLE: begin
        if (single_c) begin
          state_nxt = SETTLE;
          cnt_nxt   = CW'(1);
          lat_k_nxt = cur_k;
          lat_p_nxt = seg_p;
        end
      end
      SETTLE, HOLD: begin
        if (state == SETTLE && cnt == CW'(STABLE_CYCLES)) capture_c = 1'b1;
        if (same_c) begin
          if (state == SETTLE) begin
            if (cnt == CW'(STABLE_CYCLES)) state_nxt = HOLD;
            else                           cnt_nxt   = cnt + CW'(1);
          end
        end else if (single_c) begin
          state_nxt = SETTLE;
          cnt_nxt   = CW'(1);
          lat_k_nxt = cur_k;
          lat_p_nxt = seg_p;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  seg_pattern_decode u_decode (
    .pattern (lat_p),
    .known_c (dec_known),
    .code_c  (dec_code)
  );

  assign seen_upd_c = seen | (NUM_DIGITS'(1) << lat_k);

  // Code/valid registers, frame tracking and staleness timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_code  <= '1;
      digit_valid <= '0;
      seen        <= '0;
      frame_done  <= 1'b0;
      decode_err  <= 1'b0;
      stale       <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      decode_err <= 1'b0;
      if (frame_done) seen <= '0;
      if (capture_c) begin
        idle_cnt <= '0;
        if (dec_known) begin
          digit_code[CODE_W*int'(lat_k) +: CODE_W] <= dec_code;
          digit_valid[lat_k] <= 1'b1;
          stale              <= 1'b0;
          seen               <= seen_upd_c;
          if (&seen_upd_c) frame_done <= 1'b1;
        end else begin
          decode_err <= 1'b1;
        end
      end else if (idle_cnt != IW'(TIMEOUT_CYCLES)) begin
        idle_cnt <= idle_cnt + IW'(1);
        if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
          stale       <= 1'b1;
          digit_valid <= '0;
          seen        <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder (STABLE_CYCLES=16, TIMEOUT_CYCLES=64).
module tb_seg_scan_decoder;

  localparam int unsigned ND  = 8;
  localparam int unsigned STB = 16;
  localparam int unsigned TMO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [ND-1:0] an_n = '1;
  logic [6:0]    seg_n = '1;
  logic [8*ND-1:0] digit_code;
  logic [ND-1:0] digit_valid;
  logic          frame_done;
  logic          decode_err;
  logic          stale;

  int tests = 0;
  int fails = 0;
  int fd_total = 0;
  int err_total = 0;
  int fd0, err0;

  logic [6:0] pat_tab [0:7] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70};

  seg_scan_decoder #(
    .NUM_DIGITS     (ND),
    .STABLE_CYCLES  (STB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .digit_code  (digit_code),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .decode_err  (decode_err),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled at the rising edge before the new values settle
  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_total++;
    if (decode_err === 1'b1) err_total++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    an_n  = '1;
    seg_n = '1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic dwell(input logic [ND-1:0] a, input logic [6:0] p, input int n);
    an_n  = a;
    seg_n = ~p;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (digit_code !== '1) begin fails++; $display("FAIL reset_code: got %h expected all FF", digit_code); end
    tests++; if (digit_valid !== 8'h00) begin fails++; $display("FAIL reset_valid: got %h expected 00", digit_valid); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    tests++; if (decode_err !== 1'b0) begin fails++; $display("FAIL reset_decode_err: got %b expected 0", decode_err); end
    tests++; if (stale !== 1'b0) begin fails++; $display("FAIL reset_stale: got %b expected 0", stale); end
  endtask

  task automatic test_single_digit();
    do_reset();
    fd0 = fd_total; err0 = err_total;
    dwell(8'hFE, 7'h30, 18);
    tests++; if (digit_valid !== 8'h00) begin fails++; $display("FAIL single_early_valid: got %h expected 00", digit_valid); end
    @(negedge clk);
    tests++; if (digit_code[7:0] !== 8'h01) begin fails++; $display("FAIL single_code: got %h expected 01", digit_code[7:0]); end
    tests++; if (digit_valid !== 8'h01) begin fails++; $display("FAIL single_valid: got %h expected 01", digit_valid); end
    repeat (20) @(negedge clk);
    tests++; if (digit_code !== 64'hFFFFFFFF_FFFFFF01) begin fails++; $display("FAIL single_hold_code: got %h expected FFFFFFFFFFFFFF01", digit_code); end
    tests++; if ((err_total - err0) !== 0) begin fails++; $display("FAIL single_err: got %0d expected 0", err_total - err0); end
  endtask

  task automatic test_frame_scan();
    do_reset();
    fd0 = fd_total; err0 = err_total;
    for (int i = 0; i < 7; i++) dwell(~(8'h01 << i), pat_tab[i], 20);
    dwell(8'h7F, pat_tab[7], 19);
    tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL frame_pulse: got %b expected 1", frame_done); end
    @(negedge clk);
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL frame_pulse_end: got %b expected 0", frame_done); end
    repeat (2) @(negedge clk);
    tests++; if (digit_code !== 64'h07060504_03020100) begin fails++; $display("FAIL frame_codes: got %h expected 0706050403020100", digit_code); end
    tests++; if (digit_valid !== 8'hFF) begin fails++; $display("FAIL frame_valid: got %h expected FF", digit_valid); end
    tests++; if ((fd_total - fd0) !== 1) begin fails++; $display("FAIL frame_count: got %0d expected 1", fd_total - fd0); end
  endtask

  task automatic test_glitch();
    do_reset();
    err0 = err_total;
    for (int i = 0; i < 6; i++) dwell(8'hFB, (i % 2 == 0) ? 7'h5B : 7'h6D, 10);
    an_n = '1;
    repeat (3) @(negedge clk);
    tests++; if (digit_valid !== 8'h00) begin fails++; $display("FAIL glitch_valid: got %h expected 00", digit_valid); end
    tests++; if (digit_code !== '1) begin fails++; $display("FAIL glitch_code: got %h expected all FF", digit_code); end
    tests++; if ((err_total - err0) !== 0) begin fails++; $display("FAIL glitch_err: got %0d expected 0", err_total - err0); end
  endtask

  task automatic test_multi_anode();
    do_reset();
    err0 = err_total;
    dwell(8'hFE, 7'h30, 20);
    dwell(8'hFC, 7'h30, 30);
    tests++; if (digit_code[15:0] !== 16'hFF01) begin fails++; $display("FAIL multi_code: got %h expected FF01", digit_code[15:0]); end
    tests++; if (digit_valid !== 8'h01) begin fails++; $display("FAIL multi_valid: got %h expected 01", digit_valid); end
    tests++; if (stale !== 1'b0) begin fails++; $display("FAIL multi_stale: got %b expected 0", stale); end
    dwell(8'hFE, 7'h33, 18);
    tests++; if (digit_code[7:0] !== 8'h01) begin fails++; $display("FAIL multi_pre_code: got %h expected 01", digit_code[7:0]); end
    @(negedge clk);
    tests++; if (digit_code[7:0] !== 8'h04) begin fails++; $display("FAIL multi_new_code: got %h expected 04", digit_code[7:0]); end
    tests++; if ((err_total - err0) !== 0) begin fails++; $display("FAIL multi_err: got %0d expected 0", err_total - err0); end
  endtask

  task automatic test_codes();
    do_reset();
    dwell(8'hFB, 7'h4E, 19);
`ifdef SEG_ALPHA_EN
    tests++; if (digit_code[23:16] !== 8'h0C) begin fails++; $display("FAIL alpha_code: got %h expected 0C", digit_code[23:16]); end
    tests++; if (decode_err !== 1'b0) begin fails++; $display("FAIL alpha_err: got %b expected 0", decode_err); end
`else
    tests++; if (digit_code[23:16] !== 8'hFF) begin fails++; $display("FAIL alpha_code: got %h expected FF", digit_code[23:16]); end
    tests++; if (decode_err !== 1'b1) begin fails++; $display("FAIL alpha_err: got %b expected 1", decode_err); end
`endif
    @(negedge clk);
    dwell(8'hF7, 7'h55, 19);
    tests++; if (decode_err !== 1'b1) begin fails++; $display("FAIL unknown_err: got %b expected 1", decode_err); end
    tests++; if (digit_code[31:24] !== 8'hFF) begin fails++; $display("FAIL unknown_code: got %h expected FF", digit_code[31:24]); end
    @(negedge clk);
    tests++; if (decode_err !== 1'b0) begin fails++; $display("FAIL unknown_err_end: got %b expected 0", decode_err); end
    dwell(8'hEF, 7'h01, 20);
    dwell(8'hDF, 7'h00, 20);
    dwell(8'hBF, 7'h5B, 20);
    tests++; if (digit_code[55:32] !== 24'h05FFFE) begin fails++; $display("FAIL minus_empty_five: got %h expected 05FFFE", digit_code[55:32]); end
`ifdef SEG_ALPHA_EN
    tests++; if (digit_valid !== 8'h74) begin fails++; $display("FAIL codes_valid: got %h expected 74", digit_valid); end
`else
    tests++; if (digit_valid !== 8'h70) begin fails++; $display("FAIL codes_valid: got %h expected 70", digit_valid); end
`endif
  endtask

  task automatic test_timeout();
    do_reset();
    dwell(8'hFE, 7'h30, 19);
    tests++; if (digit_valid !== 8'h01) begin fails++; $display("FAIL to_first_valid: got %h expected 01", digit_valid); end
    an_n = '1;
    repeat (TMO - 1) @(negedge clk);
    tests++; if (stale !== 1'b0) begin fails++; $display("FAIL to_early_stale: got %b expected 0", stale); end
    @(negedge clk);
    tests++; if (stale !== 1'b1) begin fails++; $display("FAIL to_stale: got %b expected 1", stale); end
    tests++; if (digit_valid !== 8'h00) begin fails++; $display("FAIL to_valid_clr: got %h expected 00", digit_valid); end
    tests++; if (digit_code[7:0] !== 8'h01) begin fails++; $display("FAIL to_code_kept: got %h expected 01", digit_code[7:0]); end
    dwell(8'hFD, 7'h6D, 19);
    tests++; if (stale !== 1'b0) begin fails++; $display("FAIL to_stale_clr: got %b expected 0", stale); end
    tests++; if (digit_valid !== 8'h02 || digit_code[15:0] !== 16'h0201) begin fails++; $display("FAIL to_recapture: got %h/%h expected 02/0201", digit_valid, digit_code[15:0]); end
    an_n = '1;
    repeat (TMO - STB - 3) @(negedge clk);
    dwell(8'hF7, 7'h79, 19);
    tests++; if (stale !== 1'b0) begin fails++; $display("FAIL to_collide_stale: got %b expected 0", stale); end
    tests++; if (digit_valid !== 8'h0A || digit_code[31:24] !== 8'h03) begin fails++; $display("FAIL to_collide_capture: got %h/%h expected 0A/03", digit_valid, digit_code[31:24]); end
    @(negedge clk);
    tests++; if (stale !== 1'b0) begin fails++; $display("FAIL to_collide_after: got %b expected 0", stale); end
  endtask

  task automatic test_reset_mid_dwell();
    do_reset();
    dwell(8'hFD, 7'h6D, 20);
    dwell(8'hFE, 7'h7E, 10);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (digit_code !== '1 || digit_valid !== 8'h00) begin fails++; $display("FAIL mid_async_reset: got %h/%h expected all FF/00", digit_code, digit_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (18) @(negedge clk);
    tests++; if (digit_valid !== 8'h00) begin fails++; $display("FAIL mid_no_partial: got %h expected 00", digit_valid); end
    @(negedge clk);
    tests++; if (digit_valid !== 8'h01 || digit_code !== 64'hFFFFFFFF_FFFFFF00) begin fails++; $display("FAIL mid_recapture: got %h/%h expected 01/FFFFFFFFFFFFFF00", digit_valid, digit_code); end
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_frame_scan();
    test_glitch();
    test_multi_anode();
    test_codes();
    test_timeout();
    test_reset_mid_dwell();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
